// File: rtl/rgb_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pwm_ctrl
// Purpose  : Memory-mapped 8-bit PWM controller for the on-board RGB LED,
//            with an optional hardware fade engine that walks each channel's
//            current duty toward its target one step per fade interval.
// Ports    : clk             system clock
//            reset           asynchronous active-low reset
//            wr_en / rd_en   single-cycle write / read strobes
//            addr [2:0]      register select
//            wdata [7:0]     write data
//            rdata [7:0]     registered read data (1-clk latency, held)
//            led_r/g/b_n     active-low registered LED drives
//            busy            high while any current duty differs from target
// Register : 0 TGT_R, 1 TGT_G, 2 TGT_B, 3 CTRL{FADE,EN}, 4 PRESCALE,
//            5 FADE_RATE, 6 STATUS{busy} (read-only), 7 reads 0
// Revision : 1.0  initial release
// ============================================================================
module rgb_pwm_ctrl #(
  parameter logic [7:0] DEFAULT_PRESCALE  = 8'd23,
  parameter logic [7:0] DEFAULT_FADE_RATE = 8'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       led_r_n,
  output logic       led_g_n,
  output logic       led_b_n,
  output logic       busy
);

  localparam logic [2:0] c_addr_tgt_r     = 3'd0;
  localparam logic [2:0] c_addr_tgt_g     = 3'd1;
  localparam logic [2:0] c_addr_tgt_b     = 3'd2;
  localparam logic [2:0] c_addr_ctrl      = 3'd3;
  localparam logic [2:0] c_addr_prescale  = 3'd4;
  localparam logic [2:0] c_addr_fade_rate = 3'd5;
  localparam logic [2:0] c_addr_status    = 3'd6;
  localparam logic [7:0] c_pwm_last       = 8'd254;

  logic       r_en;
  logic       r_fade;
  logic [7:0] r_prescale;
  logic [7:0] r_fade_rate;
  logic [7:0] r_pre_cnt;
  logic [7:0] r_pwm_cnt;
  logic [7:0] r_fade_cnt;
  logic       r_busy;

  logic [7:0] w_tgt [3];
  logic [2:0] w_diff;
  logic [2:0] w_led_n;
  logic       w_tick;
  logic       w_frame_end;
  logic       w_fade_step;
  logic       w_fade_toggle;

  // Counters only free-run while enabled; the equality compares (not >=)
  // let an over-range pre_cnt/fade_cnt wrap through 255 before matching.
  assign w_tick        = r_en && (r_pre_cnt == r_prescale);
  assign w_frame_end   = w_tick && (r_pwm_cnt == c_pwm_last);
  assign w_fade_step   = r_fade && w_frame_end && (r_fade_cnt == r_fade_rate);
  assign w_fade_toggle = wr_en && (addr == c_addr_ctrl) && (wdata[1] != r_fade);

  // Control / configuration registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en        <= 1'b0;
      r_fade      <= 1'b0;
      r_prescale  <= DEFAULT_PRESCALE;
      r_fade_rate <= DEFAULT_FADE_RATE;
    end else if (wr_en) begin
      case (addr)
        c_addr_ctrl: begin
          r_en   <= wdata[0];
          r_fade <= wdata[1];
        end
        c_addr_prescale:  r_prescale  <= wdata;
        c_addr_fade_rate: r_fade_rate <= wdata;
        default: ;
      endcase
    end
  end

  // Prescaler, PWM frame counter and fade interval counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre_cnt  <= 8'd0;
      r_pwm_cnt  <= 8'd0;
      r_fade_cnt <= 8'd0;
    end else if (!r_en) begin
      // Disabled: park everything at zero so re-enable starts a fresh frame
      r_pre_cnt  <= 8'd0;
      r_pwm_cnt  <= 8'd0;
      r_fade_cnt <= 8'd0;
    end else begin
      r_pre_cnt <= w_tick ? 8'd0 : r_pre_cnt + 8'd1;
      if (w_tick) begin
        r_pwm_cnt <= (r_pwm_cnt == c_pwm_last) ? 8'd0 : r_pwm_cnt + 8'd1;
      end
      if (w_fade_toggle || !r_fade) begin
        r_fade_cnt <= 8'd0;
      end else if (w_frame_end) begin
        r_fade_cnt <= (r_fade_cnt == r_fade_rate) ? 8'd0 : r_fade_cnt + 8'd1;
      end
    end
  end

  // Per-channel target, current duty and registered active-low output
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    localparam logic [2:0] c_addr_tgt = 3'(gi);
    logic [7:0] r_tgt;
    logic [7:0] r_cur;
    logic       r_led_n;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_tgt <= 8'd0;
      end else if (wr_en && (addr == c_addr_tgt)) begin
        r_tgt <= wdata;
      end
    end

    // cur only moves at frame_end so a frame never sees a mid-period duty
    // change; a target written on that same edge is picked up next frame.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cur <= 8'd0;
      end else if (!r_en) begin
        r_cur <= r_tgt;
      end else if (w_frame_end) begin
        if (!r_fade) begin
          r_cur <= r_tgt;
        end else if (w_fade_step) begin
          if (r_cur < r_tgt) begin
            r_cur <= r_cur + 8'd1;
          end else if (r_cur > r_tgt) begin
            r_cur <= r_cur - 8'd1;
          end
        end
      end
    end

    // pwm_cnt tops out at 254, so duty 255 is on for the whole frame
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_led_n <= 1'b1;
      end else begin
        r_led_n <= ~(r_en && (r_pwm_cnt < r_cur));
      end
    end

    assign w_tgt[gi]   = r_tgt;
    assign w_diff[gi]  = (r_cur != r_tgt);
    assign w_led_n[gi] = r_led_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= |w_diff;
    end
  end

  // Read data captures pre-write register values on a same-cycle write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= 8'd0;
    end else if (rd_en) begin
      case (addr)
        c_addr_tgt_r:     rdata <= w_tgt[0];
        c_addr_tgt_g:     rdata <= w_tgt[1];
        c_addr_tgt_b:     rdata <= w_tgt[2];
        c_addr_ctrl:      rdata <= {6'd0, r_fade, r_en};
        c_addr_prescale:  rdata <= r_prescale;
        c_addr_fade_rate: rdata <= r_fade_rate;
        c_addr_status:    rdata <= {7'd0, r_busy};
        default:          rdata <= 8'd0;
      endcase
    end
  end

  assign led_r_n = w_led_n[0];
  assign led_g_n = w_led_n[1];
  assign led_b_n = w_led_n[2];
  assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_pwm_ctrl
// Purpose  : Scoreboard testbench for rgb_pwm_ctrl. Stimulus pushes expected
//            values; monitors pop and compare when read data or a
//            measurement of LED behaviour is presented.
// Revision : 1.0  initial release
// ============================================================================
module tb_rgb_pwm_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] rdata;
  logic       led_r_n;
  logic       led_g_n;
  logic       led_b_n;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string name;
    int    val;
  } exp_t;

  exp_t exp_rd_q[$];
  exp_t exp_meas_q[$];
  int   act_q[$];

  rgb_pwm_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .led_r_n (led_r_n),
    .led_g_n (led_g_n),
    .led_b_n (led_b_n),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // ---------------- monitors ----------------
  // Read-data monitor: rdata is due just after the edge that sampled rd_en
  initial begin
    logic fire;
    exp_t e;
    forever begin
      @(posedge clk);
      fire = rd_en;
      #1;
      if (fire) begin
        n_checks++;
        if (exp_rd_q.size() == 0) begin
          n_errors++;
          $display("FAIL rd_unexpected: got %0d required none", rdata);
        end else begin
          e = exp_rd_q.pop_front();
          if (int'(rdata) != e.val) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d", e.name, rdata, e.val);
          end
        end
      end
    end
  end

  // Measurement monitor: pops observed LED/busy values against expectations
  initial begin
    exp_t e;
    int   a;
    forever begin
      @(negedge clk);
      while (act_q.size() > 0 && exp_meas_q.size() > 0) begin
        e = exp_meas_q.pop_front();
        a = act_q.pop_front();
        n_checks++;
        if (a != e.val) begin
          n_errors++;
          $display("FAIL %s: got %0d required %0d", e.name, a, e.val);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string nm, input int expv, input int act);
    exp_t e;
    e.name = nm;
    e.val  = expv;
    exp_meas_q.push_back(e);
    act_q.push_back(act);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input int expv, input string nm);
    exp_t e;
    e.name = nm;
    e.val  = expv;
    exp_rd_q.push_back(e);
    rd_en = 1'b1;
    addr  = a;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic rdwr(input logic [2:0] a, input logic [7:0] d, input int expv, input string nm);
    exp_t e;
    e.name = nm;
    e.val  = expv;
    exp_rd_q.push_back(e);
    rd_en = 1'b1;
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  function automatic logic led(input int ch);
    case (ch)
      0:       return led_r_n;
      1:       return led_g_n;
      default: return led_b_n;
    endcase
  endfunction

  // Returns just after the first sample where the LED went high -> low
  task automatic wait_fall(input int ch, output bit ok);
    logic prev;
    logic now;
    ok   = 1'b0;
    prev = led(ch);
    for (int n = 0; n < 1200 && !ok; n++) begin
      @(posedge clk);
      #1;
      now = led(ch);
      if (prev && !now) ok = 1'b1;
      prev = now;
    end
  endtask

  // Length in clks of the next contiguous low run; -1 if it never appears/ends
  task automatic meas_run(input int ch, output int len);
    bit ok;
    bit done;
    wait_fall(ch, ok);
    len  = -1;
    done = 1'b0;
    if (ok) begin
      len = 1;
      for (int n = 0; n < 300 && !done; n++) begin
        @(posedge clk);
        #1;
        if (led(ch)) done = 1'b1;
        else len++;
      end
      if (!done) len = -1;
    end
  endtask

  task automatic count_low(output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    for (int n = 0; n < 255; n++) begin
      @(posedge clk);
      #1;
      if (!led_r_n) r++;
      if (!led_g_n) g++;
      if (!led_b_n) b++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  cr, cg, cb, len;
    bit  ok;

    // Reset asserted mid-frame with the red channel lit
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    wr(3'd0, 8'd128);
    wr(3'd3, 8'd1);
    rd(3'd0, 128, "tgt_r_readback");
    repeat (50) @(posedge clk);
    #1;
    chk("red_on_before_reset", 0, led_r_n);
    #3 reset = 1'b0;
    #1;
    chk("reset_led_r", 1, led_r_n);
    chk("reset_led_g", 1, led_g_n);
    chk("reset_led_b", 1, led_b_n);
    chk("reset_rdata", 0, rdata);
    chk("reset_busy",  0, busy);
    @(posedge clk);
    #1 reset = 1'b1;
    rd(3'd4, 23, "reset_prescale");
    rd(3'd5, 3,  "reset_fade_rate");
    rd(3'd0, 0,  "reset_tgt_r");
    rd(3'd3, 0,  "reset_ctrl");

    // Static duty
    wr(3'd4, 8'd0);
    wr(3'd0, 8'd64);
    wr(3'd1, 8'd0);
    wr(3'd2, 8'd255);
    wr(3'd3, 8'd1);
    repeat (260) @(posedge clk);
    #1;
    count_low(cr, cg, cb);
    chk("static_r_64",  64,  cr);
    chk("static_g_0",   0,   cg);
    chk("static_b_255", 255, cb);

    // Target write landing on the frame_end edge
    wr(3'd1, 8'd10);
    wait_fall(1, ok);
    chk("boundary_align", 1, ok);
    repeat (253) @(posedge clk);
    #1;
    wr(3'd1, 8'd200);
    meas_run(1, len);
    chk("boundary_old_tgt_10", 10, len);
    meas_run(1, len);
    chk("boundary_new_tgt_200", 200, len);

    // Disable mid-frame while a fade is in progress
    wr(3'd3, 8'd3);
    wr(3'd0, 8'd200);
    repeat (2) @(posedge clk);
    #1;
    chk("fade_busy_high", 1, busy);
    rd(3'd6, 1, "status_busy_1");
    wait_fall(0, ok);
    chk("disable_align", 1, ok);
    repeat (99) @(posedge clk);
    #1;
    chk("green_on_at_pwm100", 0, led_g_n);
    chk("blue_on_at_pwm100",  0, led_b_n);
    wr(3'd3, 8'd0);
    @(posedge clk);
    #1;
    chk("disable_led_r", 1, led_r_n);
    chk("disable_led_g", 1, led_g_n);
    chk("disable_led_b", 1, led_b_n);
    @(posedge clk);
    #1;
    chk("disable_busy_low", 0, busy);
    rd(3'd6, 0, "status_busy_0");
    wr(3'd3, 8'd1);
    meas_run(0, len);
    chk("reenable_full_frame_200", 200, len);

    // Fade 0 -> 5, one step per frame
    wr(3'd3, 8'd0);
    wr(3'd0, 8'd0);
    wr(3'd5, 8'd0);
    wr(3'd3, 8'd3);
    wr(3'd0, 8'd5);
    repeat (2) @(posedge clk);
    #1;
    chk("fade5_busy_high", 1, busy);
    for (int k = 1; k <= 4; k++) begin
      meas_run(0, len);
      chk($sformatf("fade_step_%0d", k), k, len);
    end
    chk("fade_busy_mid", 1, busy);
    meas_run(0, len);
    chk("fade_step_5", 5, len);
    chk("fade_busy_done", 0, busy);
    meas_run(0, len);
    chk("fade_hold_5", 5, len);

    // Register access
    wr(3'd3, 8'd0);
    wr(3'd0, 8'h11);
    wr(3'd1, 8'h22);
    wr(3'd2, 8'h33);
    wr(3'd3, 8'hFE);
    wr(3'd4, 8'h44);
    wr(3'd5, 8'h55);
    wr(3'd6, 8'hAA);
    wr(3'd7, 8'hBB);
    repeat (2) @(posedge clk);
    #1;
    rd(3'd0, 8'h11, "reg_tgt_r");
    rd(3'd1, 8'h22, "reg_tgt_g");
    rd(3'd2, 8'h33, "reg_tgt_b");
    rd(3'd3, 8'h02, "reg_ctrl_masked");
    rd(3'd4, 8'h44, "reg_prescale");
    rd(3'd5, 8'h55, "reg_fade_rate");
    rd(3'd6, 0,     "reg_status");
    rd(3'd7, 0,     "reg_addr7");
    rdwr(3'd0, 8'h99, 8'h11, "rdwr_returns_old");
    rd(3'd0, 8'h99, "rdwr_new_value");
    repeat (3) @(posedge clk);
    #1;
    chk("rdata_hold", 8'h99, rdata);

    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_rd_q.size() + exp_meas_q.size() + act_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0",
               exp_rd_q.size() + exp_meas_q.size() + act_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
